// File: rtl/iobuf_ctrl_if.sv
// Handshake and address-buffer signals between the IO sequencer and its environment.
// The slave modport is the controller's view; master is the driver/bench view.
interface iobuf_ctrl_if #(
  parameter int unsigned AWIDTH = 16
);
  logic              Start;
  logic [AWIDTH-1:0] Num_Steps;
  logic              Stall;
  logic [1:0]        DBuf_Status;
  logic [AWIDTH-1:0] ABuf_Addr;
  logic              DBuf_Wea;
  logic              Ld_Valid;
  logic              Busy;
  logic              Done;

  modport slave (
    input  Start, Num_Steps, Stall, DBuf_Status,
    output ABuf_Addr, DBuf_Wea, Ld_Valid, Busy, Done
  );

  modport master (
    output Start, Num_Steps, Stall, DBuf_Status,
    input  ABuf_Addr, DBuf_Wea, Ld_Valid, Busy, Done
  );
endinterface

// File: rtl/iobuf_ctrl.sv
// IO sequencer: walks the address buffer, turning each status word into a data-buffer
// store strobe or a load-valid pulse for the CGRA, then drains and signals Done.
module iobuf_ctrl #(
  parameter int unsigned DWIDTH = 32,
  parameter int unsigned AWIDTH = 16
) (
  input  logic        Clk,
  input  logic        Rst,
  iobuf_ctrl_if.slave bus
);

  if (DWIDTH == 0 || AWIDTH == 0) begin : g_bad_param
    $error("iobuf_ctrl: DWIDTH and AWIDTH must be non-zero");
  end

  localparam logic [1:0]        StsLoad  = 2'b01;
  localparam logic [1:0]        StsStore = 2'b10;
  localparam logic [1:0]        StsEnd   = 2'b11;
  localparam logic [AWIDTH-1:0] One      = AWIDTH'(1);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StFin} state_e;

  state_e            state_q, state_d;
  logic [AWIDTH-1:0] cnt_q, cnt_d;
  logic [AWIDTH-1:0] nsteps_q, nsteps_d;
  logic              v1_q, v1_d;
  logic              ld_q, ld_d;
  logic              busy_q, done_q;
  logic              issue, end_hit, last_issue;

  always_comb begin
    issue      = (state_q == StRun) && !bus.Stall;
    end_hit    = (state_q == StRun) && v1_q && (bus.DBuf_Status == StsEnd);
    last_issue = issue && (cnt_q == (nsteps_q - One));

    state_d  = state_q;
    cnt_d    = cnt_q;
    nsteps_d = nsteps_q;
    // An end marker kills the issue made in the same cycle.
    v1_d     = issue && !end_hit;
    ld_d     = v1_q && (bus.DBuf_Status == StsLoad);

    unique case (state_q)
      StIdle: begin
        if (bus.Start) begin
          nsteps_d = bus.Num_Steps;
          cnt_d    = '0;
          state_d  = (bus.Num_Steps == '0) ? StFin : StRun;
        end
      end
      StRun: begin
        if (issue) cnt_d = cnt_q + One;
        if (end_hit || last_issue) state_d = StDrain;
      end
      StDrain: begin
        if (!v1_q && !ld_q) state_d = StFin;
      end
      StFin: begin
        cnt_d   = '0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      nsteps_q <= '0;
      v1_q     <= 1'b0;
      ld_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      nsteps_q <= nsteps_d;
      v1_q     <= v1_d;
      ld_q     <= ld_d;
      busy_q   <= (state_d != StIdle);
      done_q   <= (state_d == StFin);
    end
  end

  assign bus.ABuf_Addr = cnt_q;
  assign bus.DBuf_Wea  = v1_q && !bus.Stall && (bus.DBuf_Status == StsStore);
  assign bus.Ld_Valid  = ld_q;
  assign bus.Busy      = busy_q;
  assign bus.Done      = done_q;

endmodule

// File: tb/tb_iobuf_ctrl.sv
// Directed bench for iobuf_ctrl; the bench models the address buffer as a 1-cycle
// status lookup and checks every output cycle against hand-derived tables.
module tb_iobuf_ctrl;
  localparam int unsigned AW = 4;
  localparam int unsigned DW = 32;

  logic Clk = 1'b0;
  logic Rst;
  always #5 Clk = ~Clk;

  iobuf_ctrl_if #(.AWIDTH(AW)) bus ();
  iobuf_ctrl #(.DWIDTH(DW), .AWIDTH(AW)) dut (.Clk(Clk), .Rst(Rst), .bus(bus));

  logic [1:0] mem [16];
  always @(posedge Clk) bus.DBuf_Status <= mem[bus.ABuf_Addr];

  int errors = 0;
  int checks = 0;

  // Per-cycle expectations: address (-1 = not checked), {wea,ld,busy,done}, stall, start.
  int       ea  [20];
  logic [3:0] ef [20];
  logic     es  [20];
  logic     est [20];

  task automatic nxt();
    @(negedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input int idx, input int exp_addr,
                     input logic [3:0] exp_f);
    logic [3:0] obs;
    obs = {bus.DBuf_Wea, bus.Ld_Valid, bus.Busy, bus.Done};
    checks++;
    assert (obs === exp_f) else begin
      errors++;
      $error("FAIL %s[%0d] wea/ld/busy/done: got %b want %b", tag, idx, obs, exp_f);
    end
    if (exp_addr >= 0) begin
      checks++;
      assert (int'(bus.ABuf_Addr) === exp_addr) else begin
        errors++;
        $error("FAIL %s[%0d] addr: got %0d want %0d", tag, idx, bus.ABuf_Addr, exp_addr);
      end
    end
  endtask

  task automatic clr();
    for (int i = 0; i < 20; i++) begin
      ea[i] = -1; ef[i] = 4'b0000; es[i] = 1'b0; est[i] = 1'b0;
    end
  endtask

  task automatic fill(input logic [1:0] v);
    for (int i = 0; i < 16; i++) mem[i] = v;
  endtask

  task automatic run(input string tag, input int n, input int len);
    bus.Start = 1'b1;
    bus.Num_Steps = AW'(n);
    nxt();
    for (int i = 0; i < len; i++) begin
      bus.Stall = es[i];
      bus.Start = est[i];
      bus.Num_Steps = est[i] ? AW'(1) : AW'(n);
      #1;
      chk(tag, i, ea[i], ef[i]);
      nxt();
    end
    bus.Start = 1'b0;
    bus.Stall = 1'b0;
  endtask

  initial begin
    fill(2'b00);
    Rst = 1'b1;
    bus.Start = 1'b0;
    bus.Num_Steps = '0;
    bus.Stall = 1'b0;
    nxt();
    nxt();
    chk("reset", 0, 0, 4'b0000);
    Rst = 1'b0;
    nxt();

    // Basic: load, store, nop, load.
    clr();
    mem[0] = 2'b01; mem[1] = 2'b10; mem[2] = 2'b00; mem[3] = 2'b01;
    ea[0] = 0; ea[1] = 1; ea[2] = 2; ea[3] = 3;
    ef[0] = 4'b0010; ef[1] = 4'b0010; ef[2] = 4'b1110; ef[3] = 4'b0010;
    ef[4] = 4'b0010; ef[5] = 4'b0110; ef[6] = 4'b0010; ef[7] = 4'b0011;
    run("basic", 4, 12);

    // Two stall cycles after the first issue.
    clr();
    fill(2'b00);
    mem[1] = 2'b10; mem[2] = 2'b01;
    ea[0] = 0; ea[1] = 1; ea[2] = 1; ea[3] = 1; ea[4] = 2;
    es[1] = 1'b1; es[2] = 1'b1;
    ef[0] = 4'b0010; ef[1] = 4'b0010; ef[2] = 4'b0010; ef[3] = 4'b0010;
    ef[4] = 4'b1010; ef[5] = 4'b0010; ef[6] = 4'b0110; ef[7] = 4'b0010;
    ef[8] = 4'b0011;
    run("stall", 3, 11);

    // End marker at address 2 squashes the address-3 issue.
    clr();
    fill(2'b10);
    mem[0] = 2'b01; mem[2] = 2'b11; mem[3] = 2'b01;
    ea[0] = 0; ea[1] = 1; ea[2] = 2; ea[3] = 3;
    ef[0] = 4'b0010; ef[1] = 4'b0010; ef[2] = 4'b1110; ef[3] = 4'b0010;
    ef[4] = 4'b0010; ef[5] = 4'b0011;
    run("endmark", 8, 8);

    // Zero steps: straight to FIN.
    clr();
    ef[0] = 4'b0011;
    run("zero", 0, 3);

    // Stall in DRAIN masks the store strobe but not the drain.
    clr();
    fill(2'b10);
    ea[0] = 0; ea[1] = 1;
    es[2] = 1'b1; es[3] = 1'b1;
    ef[0] = 4'b0010; ef[1] = 4'b1010; ef[2] = 4'b0010; ef[3] = 4'b0010;
    ef[4] = 4'b0011;
    run("drainstall", 2, 7);

    // Reset mid-run at step 5, with Start held alongside it.
    fill(2'b01);
    bus.Start = 1'b1;
    bus.Num_Steps = AW'(10);
    nxt();
    bus.Start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("midrun", i, i, (i < 2) ? 4'b0010 : 4'b0110);
      if (i == 5) begin
        Rst = 1'b1;
        bus.Start = 1'b1;
      end
      nxt();
    end
    bus.Start = 1'b0;
    chk("rst_abort", 0, 0, 4'b0000);
    Rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      nxt();
      chk("rst_idle", i, -1, 4'b0000);
    end
    clr();
    ea[0] = 0; ea[1] = 1;
    ef[0] = 4'b0010; ef[1] = 4'b0010; ef[2] = 4'b0110; ef[3] = 4'b0110;
    ef[4] = 4'b0010; ef[5] = 4'b0011;
    run("restart", 2, 8);

    // Start pulses while busy (RUN and FIN) are ignored.
    clr();
    fill(2'b00);
    ea[0] = 0; ea[1] = 1; ea[2] = 2;
    est[1] = 1'b1; est[5] = 1'b1;
    ef[0] = 4'b0010; ef[1] = 4'b0010; ef[2] = 4'b0010; ef[3] = 4'b0010;
    ef[4] = 4'b0010; ef[5] = 4'b0011;
    run("busystart", 3, 9);

    // Maximum step count: addresses 0..14 then drain.
    clr();
    for (int i = 0; i < 15; i++) begin
      ea[i] = i;
      ef[i] = 4'b0010;
    end
    ef[15] = 4'b0010; ef[16] = 4'b0010; ef[17] = 4'b0011;
    run("maxsteps", 15, 19);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/iobuf_ctrl.md
IOBUF_CTRL -- requirements
Module: iobuf_ctrl

Interface
REQ-001 Parameter DWIDTH, default 32: data width, shared with the IO buffer.
REQ-002 Parameter AWIDTH, default 16: address-buffer address width and step-count width.
REQ-003 Clk  input  1: single clock; all state updates on the rising edge.
REQ-004 Rst  input  1: reset; synchronous and active-high.
REQ-005 Start  input  1: single-cycle request to run one IO sequence; honoured only in IDLE.
REQ-006 Num_Steps  input  AWIDTH: number of address-buffer entries to issue; sampled on an accepted Start.
REQ-007 Stall  input  1: when high, the CGRA cannot accept or produce data this cycle.
REQ-008 DBuf_Status  input  2: status word from the address buffer; valid one cycle after ABuf_Addr is presented.
REQ-009 ABuf_Addr  output  AWIDTH: address-buffer read address.
REQ-010 DBuf_Wea  output  1: data-buffer write enable.
REQ-011 Ld_Valid  output  1: data-buffer Data_Out holds a valid load for the CGRA this cycle.
REQ-012 Busy  output  1: high in every state except IDLE.
REQ-013 Done  output  1: single-cycle completion pulse.

Function
REQ-014 Status encoding SHALL be:
- 2'b00 = nop
- 2'b01 = load (read DBuf to CGRA)
- 2'b10 = store (write CGRA result to DBuf)
- 2'b11 = end marker
REQ-015 The FSM SHALL use states IDLE, RUN, DRAIN and FIN; FIN lasts exactly one cycle with Done=1.
REQ-016 IDLE SHALL go to RUN on Start=1 with Num_Steps!=0, and to FIN on Start=1 with Num_Steps=0, issuing nothing.
REQ-017 An issue SHALL occur in a cycle where state=RUN and Stall=0.
- ABuf_Addr equals the step counter, which starts at 0.
- The counter increments by 1 per issue.
- The counter holds while stalled.
REQ-018 A 1-bit valid register v1 SHALL capture issue each cycle; v1 marks DBuf_Status and DBuf address as valid.
REQ-019 DBuf_Wea SHALL be combinational: v1 AND Stall=0 AND DBuf_Status=2'b10.
REQ-020 Ld_Valid SHALL be registered: it is set to (v1 AND DBuf_Status=2'b01), aligned with the 1-cycle DBuf read latency, i.e. 2 cycles after issue.
REQ-021 A stalled cycle SHALL clear v1 for the following cycle; because the held address is re-issued once Stall drops, each entry produces exactly one Wea or Ld_Valid.
REQ-022 RUN SHALL go to DRAIN in the cycle that issues step Num_Steps-1.
REQ-023 End marker: v1 AND DBuf_Status=2'b11 in RUN SHALL:
- move the FSM to DRAIN;
- squash the issue made that same cycle, so that v1 is 0 next cycle.
REQ-024 DRAIN SHALL issue nothing and SHALL go to FIN once v1=0 and the Ld_Valid pipeline is empty; FIN then returns to IDLE.
REQ-025 Start SHALL be ignored while Busy=1; Num_Steps SHALL be ignored except on an accepted Start.
REQ-026 The counter SHALL wrap modulo 2^AWIDTH; Num_Steps=2^AWIDTH-1 issues addresses 0..2^AWIDTH-2.
REQ-027 Stall asserted in DRAIN SHALL suppress DBuf_Wea but SHALL NOT block DRAIN-to-FIN progress.

Reset
REQ-028 With Rst=1, on the next edge:
- state goes to IDLE;
- the counter, v1 and the Ld_Valid register clear;
- ABuf_Addr, Ld_Valid, Busy and Done read 0, and DBuf_Wea is 0.
REQ-029 Rst SHALL take priority over Start and Stall, and SHALL abort a sequence in any state without producing Done.

Verification
REQ-030 Num_Steps=4, statuses {01,10,00,01}, Stall=0 -> ABuf_Addr 0..3 on consecutive cycles; Wea high exactly once, for address 1; Ld_Valid high for addresses 0 and 3; Done one cycle after the drain completes.
REQ-031 Num_Steps=3, Stall=1 for 2 cycles after the first issue -> ABuf_Addr holds at 1 during the stall; exactly 3 status-valid cycles; no duplicate Wea.
REQ-032 Num_Steps=8, status at address 2 = 11 -> issue stops; the address-3 issue is squashed; no Wea or Ld_Valid from address 3; Done follows.
REQ-033 Num_Steps=0 with Start -> no issue; Busy for 1 cycle; Done pulse.
REQ-034 Rst asserted mid-RUN at step 5 -> all outputs 0 next cycle; no Done; a new Start restarts at ABuf_Addr 0.
REQ-035 Start pulsed during RUN -> ignored; step count unchanged; exactly one Done per accepted Start.
